// File: rtl/kmac_msg_fifo_if.sv
// Write/read handshake bundle between the register interface, the message
// FIFO and the SHA3 core. The master side drives words in and consumes entries.
`timescale 1ns/1ps
interface kmac_msg_fifo_if #(
    parameter int MsgWidth     = 64,
    parameter int RegIntfWidth = 32
);
    localparam int Ratio = MsgWidth / RegIntfWidth;

    logic                    wr_valid;
    logic                    wr_ready;
    logic [RegIntfWidth-1:0] wr_data;
    logic                    wr_last;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [MsgWidth-1:0]     rd_data;
    logic [Ratio-1:0]        rd_mask;
    logic                    rd_last;

    modport master (
        output wr_valid, wr_data, wr_last, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_mask, rd_last
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_mask, rd_last
    );
endinterface

// File: rtl/kmac_msg_fifo.sv
// KMAC message buffer: packs register-width words into SHA3-width entries and
// queues them so the SHA3 absorb phase never back-pressures register writes.
`timescale 1ns/1ps
module kmac_msg_fifo #(
    parameter int MsgWidth         = 64,
    parameter int RegIntfWidth     = 32,
    parameter int RegLatency       = 5,
    parameter int Sha3Latency      = 72,
    parameter int AlmostFullMargin = 2,
    parameter int StatusW          = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    kmac_msg_fifo_if.slave     bus,
    output logic [StatusW-1:0] depth,
    output logic               empty,
    output logic               full,
    output logic               almost_full
);
    localparam int Ratio        = MsgWidth / RegIntfWidth;
    // Words the register side can push while one SHA3 block is processed.
    localparam int WordsPerSha3 = (Sha3Latency + RegLatency - 1) / RegLatency;
    localparam int Depth        = 2 + (RegIntfWidth * WordsPerSha3 + MsgWidth - 1) / MsgWidth;
    localparam int DepthW       = $clog2(Depth + 1);
    localparam int PtrW         = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int WcntW        = (Ratio > 1) ? $clog2(Ratio) : 1;

    if (MsgWidth % RegIntfWidth != 0) begin : g_chk_ratio
        $error("kmac_msg_fifo: MsgWidth must be a multiple of RegIntfWidth");
    end
    if (AlmostFullMargin >= Depth) begin : g_chk_margin
        $error("kmac_msg_fifo: AlmostFullMargin must be below Depth");
    end
    if (StatusW < DepthW) begin : g_chk_status
        $error("kmac_msg_fifo: StatusW too narrow for FIFO depth");
    end

    logic [PtrW-1:0]     wptr;
    logic [PtrW-1:0]     rptr;
    logic [DepthW-1:0]   cnt;
    logic [WcntW-1:0]    wcnt;
    logic [Ratio-1:0]    pack_mask;
    logic [MsgWidth-1:0] pack_data;

    logic [MsgWidth-1:0] mem_data [Depth];
    logic [Ratio-1:0]    mem_mask [Depth];
    logic                mem_last [Depth];

    logic                wr_acc;
    logic                entry_done;
    logic                push;
    logic                pop;
    logic [MsgWidth-1:0] push_data;
    logic [Ratio-1:0]    push_mask;

    // Pointers run modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full        = (cnt == DepthW'(Depth));
    assign empty       = (cnt == '0);
    assign almost_full = (cnt >= DepthW'(Depth - AlmostFullMargin));
    assign depth       = StatusW'(cnt);

    assign bus.wr_ready = ~full;
    assign bus.rd_valid = ~empty;

    assign wr_acc     = bus.wr_valid & bus.wr_ready;
    assign entry_done = (wcnt == WcntW'(Ratio - 1)) | bus.wr_last;
    assign push       = wr_acc & entry_done;
    assign pop        = bus.rd_valid & bus.rd_ready;

    // Merge the incoming word into the packed entry; slots never written stay zero.
    always_comb begin
        push_data = '0;
        push_mask = pack_mask;
        for (int k = 0; k < Ratio; k++) begin
            if (wcnt == WcntW'(k)) begin
                push_data[k*RegIntfWidth +: RegIntfWidth] = bus.wr_data;
                push_mask[k]                              = 1'b1;
            end else if (pack_mask[k]) begin
                push_data[k*RegIntfWidth +: RegIntfWidth] = pack_data[k*RegIntfWidth +: RegIntfWidth];
            end
        end
    end

    // Packer control: word slot index and populated-slot mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            pack_mask <= '0;
        end else if (clear) begin
            wcnt      <= '0;
            pack_mask <= '0;
        end else if (wr_acc) begin
            if (entry_done) begin
                wcnt      <= '0;
                pack_mask <= '0;
            end else begin
                wcnt      <= wcnt + WcntW'(1);
                pack_mask <= push_mask;
            end
        end
    end

    // Packer data holding; stale contents are hidden by pack_mask.
    always_ff @(posedge clk) begin
        if (wr_acc && !entry_done) begin
            pack_data <= push_data;
        end
    end

    // FIFO control: pointers and occupancy; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + DepthW'(1);
                2'b01:   cnt <= cnt - DepthW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO storage: written on a completing word, no reset needed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_data[wptr] <= push_data;
            mem_mask[wptr] <= push_mask;
            mem_last[wptr] <= bus.wr_last;
        end
    end

    // Head entry view; forced to zero when nothing is stored.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_mask = '0;
        bus.rd_last = 1'b0;
        if (!empty) begin
            bus.rd_data = mem_data[rptr];
            bus.rd_mask = mem_mask[rptr];
            bus.rd_last = mem_last[rptr];
        end
    end
endmodule

// File: tb/tb_kmac_msg_fifo.sv
// Directed bench for kmac_msg_fifo: packing, masks, fill/stall, streaming
// across pointer wrap, clear and asynchronous reset.
`timescale 1ns/1ps
module tb_kmac_msg_fifo;
    localparam int MW    = 64;
    localparam int RW    = 32;
    localparam int DEPTH = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] depth;
    logic       empty;
    logic       full;
    logic       almost_full;

    int pass_cnt  = 0;
    int total_cnt = 0;

    kmac_msg_fifo_if #(.MsgWidth(MW), .RegIntfWidth(RW)) bus ();

    kmac_msg_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .bus         (bus.slave),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; the word is presented across one rising edge.
    task automatic put_word(input logic [31:0] d, input logic l);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = l;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic pop_one();
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (depth !== 5'd0) $display("FAIL reset_depth got %0d want 0", depth); else pass_cnt++;
        total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); else pass_cnt++;
        total_cnt++; if (bus.rd_mask !== 2'b00) $display("FAIL reset_rd_mask got %b want 00", bus.rd_mask); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 64'd0) $display("FAIL reset_rd_data got %h want 0", bus.rd_data); else pass_cnt++;
        total_cnt++; if (full !== 1'b0 || almost_full !== 1'b0) $display("FAIL reset_full_af got %b%b want 00", full, almost_full); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_entry();
        put_word(32'hAAAA0001, 1'b0);
        total_cnt++; if (bus.rd_valid !== 1'b0 || depth !== 5'd0) $display("FAIL half_entry_hidden got vld=%b depth=%0d want 0/0", bus.rd_valid, depth); else pass_cnt++;
        put_word(32'hBBBB0002, 1'b0);
        total_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL entry_rd_valid got %b want 1", bus.rd_valid); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 64'hBBBB0002_AAAA0001) $display("FAIL entry_rd_data got %h want bbbb0002aaaa0001", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.rd_mask !== 2'b11) $display("FAIL entry_rd_mask got %b want 11", bus.rd_mask); else pass_cnt++;
        total_cnt++; if (bus.rd_last !== 1'b0) $display("FAIL entry_rd_last got %b want 0", bus.rd_last); else pass_cnt++;
        total_cnt++; if (depth !== 5'd1 || empty !== 1'b0) $display("FAIL entry_depth got %0d/%b want 1/0", depth, empty); else pass_cnt++;
        pop_one();
        total_cnt++; if (empty !== 1'b1 || depth !== 5'd0) $display("FAIL entry_pop got depth=%0d empty=%b want 0/1", depth, empty); else pass_cnt++;
    endtask

    task automatic test_last_word();
        put_word(32'h12345678, 1'b1);
        total_cnt++; if (bus.rd_data !== 64'h00000000_12345678) $display("FAIL last_rd_data got %h want 0000000012345678", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.rd_mask !== 2'b01) $display("FAIL last_rd_mask got %b want 01", bus.rd_mask); else pass_cnt++;
        total_cnt++; if (bus.rd_last !== 1'b1) $display("FAIL last_rd_last got %b want 1", bus.rd_last); else pass_cnt++;
        total_cnt++; if (depth !== 5'd1) $display("FAIL last_depth got %0d want 1", depth); else pass_cnt++;
        pop_one();
        total_cnt++; if (empty !== 1'b1) $display("FAIL last_pop_empty got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_fill();
        int e;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            put_word(32'h1000_0000 + i, 1'b0);
            if (i % 2 == 1) begin
                e = (i + 1) / 2;
                total_cnt++; if (depth !== 5'(e)) $display("FAIL fill_depth_%0d got %0d want %0d", e, depth, e); else pass_cnt++;
                total_cnt++; if (almost_full !== (e >= 8)) $display("FAIL fill_almost_full_%0d got %b want %b", e, almost_full, (e >= 8)); else pass_cnt++;
                total_cnt++; if (full !== (e == 10)) $display("FAIL fill_full_%0d got %b want %b", e, full, (e == 10)); else pass_cnt++;
            end
        end
        total_cnt++; if (bus.wr_ready !== 1'b0) $display("FAIL fill_wr_ready got %b want 0", bus.wr_ready); else pass_cnt++;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hDEAD0000;
        repeat (3) @(negedge clk);
        bus.wr_valid = 1'b0;
        total_cnt++; if (depth !== 5'd10 || full !== 1'b1) $display("FAIL stall_depth got %0d/%b want 10/1", depth, full); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 64'h10000001_10000000) $display("FAIL stall_head got %h want 1000000110000000", bus.rd_data); else pass_cnt++;
    endtask

    // FIFO starts full with the entries from test_fill; writes stream every
    // cycle while the reader takes an entry every other cycle.
    task automatic test_back_to_back();
        logic [63:0] q[$];
        logic [31:0] lo;
        logic        half;
        logic        exp_ready;
        int          nxt;
        lo   = '0;
        half = 1'b0;
        nxt  = 0;
        for (int e = 0; e < DEPTH; e++) begin
            q.push_back({32'h1000_0000 + 32'(2*e + 1), 32'h1000_0000 + 32'(2*e)});
        end
        for (int c = 0; c < 41; c++) begin
            bus.rd_ready = (c % 2 == 0);
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'h2000_0000 + nxt;
            exp_ready    = (q.size() < DEPTH);
            total_cnt++; if (bus.wr_ready !== exp_ready) $display("FAIL stream_wr_ready_c%0d got %b want %b", c, bus.wr_ready, exp_ready); else pass_cnt++;
            total_cnt++; if (depth !== 5'(q.size()) || depth < 5'd9) $display("FAIL stream_depth_c%0d got %0d want %0d", c, depth, q.size()); else pass_cnt++;
            if (bus.rd_ready && q.size() > 0) begin
                total_cnt++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== q[0]) $display("FAIL stream_data_c%0d got %h want %h", c, bus.rd_data, q[0]); else pass_cnt++;
                void'(q.pop_front());
            end
            if (exp_ready) begin
                if (half) begin
                    q.push_back({bus.wr_data, lo});
                    half = 1'b0;
                end else begin
                    lo   = bus.wr_data;
                    half = 1'b1;
                end
                nxt++;
            end
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (q.size() > 0) begin
                bus.rd_ready = 1'b1;
                total_cnt++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== q[0]) $display("FAIL drain_data_%0d got %h want %h", k, bus.rd_data, q[0]); else pass_cnt++;
                void'(q.pop_front());
                @(negedge clk);
            end
        end
        bus.rd_ready = 1'b0;
        total_cnt++; if (empty !== 1'b1 || depth !== 5'd0) $display("FAIL drain_empty got %b/%0d want 1/0", empty, depth); else pass_cnt++;
    endtask

    task automatic test_clear();
        put_word(32'h11111111, 1'b0);
        total_cnt++; if (depth !== 5'd0) $display("FAIL clear_pre_depth got %0d want 0", depth); else pass_cnt++;
        clear        = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h22222222;
        @(negedge clk);
        clear        = 1'b0;
        bus.wr_valid = 1'b0;
        total_cnt++; if (depth !== 5'd0 || empty !== 1'b1 || bus.rd_valid !== 1'b0) $display("FAIL clear_state got depth=%0d empty=%b want 0/1", depth, empty); else pass_cnt++;
        put_word(32'h33333333, 1'b0);
        put_word(32'h44444444, 1'b0);
        total_cnt++; if (bus.rd_data !== 64'h44444444_33333333) $display("FAIL clear_next_data got %h want 4444444433333333", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.rd_mask !== 2'b11 || depth !== 5'd1) $display("FAIL clear_next_mask got %b/%0d want 11/1", bus.rd_mask, depth); else pass_cnt++;
        clear        = 1'b1;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
        bus.rd_ready = 1'b0;
        total_cnt++; if (empty !== 1'b1 || depth !== 5'd0) $display("FAIL clear_stored got %b/%0d want 1/0", empty, depth); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        put_word(32'h55555555, 1'b0);
        put_word(32'h66666666, 1'b0);
        put_word(32'h77777777, 1'b0);
        total_cnt++; if (depth !== 5'd1) $display("FAIL arst_pre_depth got %0d want 1", depth); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (depth !== 5'd0 || empty !== 1'b1) $display("FAIL arst_depth got %0d/%b want 0/1", depth, empty); else pass_cnt++;
        total_cnt++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 64'd0) $display("FAIL arst_rd got %b/%h want 0/0", bus.rd_valid, bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.wr_ready !== 1'b1) $display("FAIL arst_wr_ready got %b want 1", bus.wr_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put_word(32'h88888888, 1'b0);
        put_word(32'h99999999, 1'b0);
        total_cnt++; if (bus.rd_data !== 64'h99999999_88888888 || bus.rd_mask !== 2'b11) $display("FAIL arst_next got %h/%b want 9999999988888888/11", bus.rd_data, bus.rd_mask); else pass_cnt++;
        pop_one();
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;
        bus.rd_ready = 1'b0;
        test_reset();
        test_full_entry();
        test_last_word();
        test_fill();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
